fetch_stage: RTL and testbench

//   Instruction fetch stage: holds the PC, issues one instruction-memory read at a time over a
//   req/gnt/ack handshake, and presents the fetched word and its opcode field to the main decoder.

---
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time over req/gnt/ack,
// and holds the returned word for the decoder until downstream consumes it.
module fetch_stage #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic [6:0]            op,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [31:0]           fetch_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [31:0]           NOP_INSTR  = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(3'd4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(2'b11);

  state_t                  state_r;
  state_t                  state_next_s;
  logic [ADDR_WIDTH-1:0]   pc_r;
  logic [ADDR_WIDTH-1:0]   pc_next_s;
  logic [31:0]             instr_r;
  logic [31:0]             fetch_count_r;
  logic                    capture_s;
  logic                    consume_s;

  // Next-state, capture/consume strobes and the redirect/sequential PC choice.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    capture_s    = 1'b0;
    consume_s    = 1'b0;
    case (state_r)
      FETCH: begin
        // A late ack from a request issued before reset lands here and is dropped.
        if (imem_gnt) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = FETCH;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          capture_s    = 1'b1;
          state_next_s = VALID;
        end else begin
          state_next_s = WAIT;
        end
      end
      VALID: begin
        if (instr_ready) begin
          consume_s    = 1'b1;
          state_next_s = FETCH;
          if (branch_taken) begin
            pc_next_s = branch_target & ALIGN_MASK;
          end else begin
            pc_next_s = pc_r + PC_STEP;
          end
        end else begin
          state_next_s = VALID;
        end
      end
      default: begin
        state_next_s = FETCH;
      end
    endcase
  end

  // State, PC, held instruction and consumed-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      instr_r       <= NOP_INSTR;
      fetch_count_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      if (capture_s) begin
        instr_r <= imem_rdata;
      end else begin
        instr_r <= instr_r;
      end
      if (consume_s) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end else begin
        fetch_count_r <= fetch_count_r;
      end
    end
  end

  // Request is masked by rst so nothing is issued while the stage is held in reset.
  assign imem_req    = (state_r == FETCH) && !rst;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign op          = instr_r[6:0];
  assign instr_valid = (state_r == VALID);
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: inputs driven and outputs checked on the falling edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .pc(pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge with the DUT in FETCH at exp_addr; ends on a falling edge in FETCH.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                          input logic br, input logic [31:0] tgt);
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, exp_addr);
    imem_gnt = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    check("wait_req", 32'(imem_req), 32'd0);
    check("wait_valid", 32'(instr_valid), 32'd0);
    imem_gnt = 1'b0; imem_ack = 1'b1; imem_rdata = data;
    @(negedge clk);
    check("valid_flag", 32'(instr_valid), 32'd1);
    check("valid_instr", instr, data);
    check("valid_op", 32'(op), {25'd0, data[6:0]});
    check("valid_pc", pc, exp_addr);
    imem_ack = 1'b0; instr_ready = 1'b1; branch_taken = br; branch_target = tgt;
    @(negedge clk);
    instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_op", 32'(op), 32'h13);
    check("rst_pc", pc, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    rst = 1'b0;
    #1;

    // First fetch and back-to-back sequential consumption
    do_fetch(32'h0, 32'h0050_0093, 1'b0, 32'd0);
    check("t1_addr", imem_addr, 32'h4);
    check("t1_count", fetch_count, 32'd1);
    do_fetch(32'h4, 32'h0010_0113, 1'b0, 32'd0);
    do_fetch(32'h8, 32'h0020_0193, 1'b0, 32'd0);
    do_fetch(32'hC, 32'h0030_0213, 1'b0, 32'd0);
    check("t2_addr", imem_addr, 32'h10);
    check("t2_count", fetch_count, 32'd4);

    // Downstream stall in VALID; ack and branch inputs must be ignored
    check("t3_req", 32'(imem_req), 32'd1);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; branch_taken = 1'b1; branch_target = 32'h100;
    for (int i = 0; i < 5; i++) begin
      check("t3_instr", instr, 32'h1234_5678);
      check("t3_pc", pc, 32'h10);
      check("t3_valid", 32'(instr_valid), 32'd1);
      check("t3_req_low", 32'(imem_req), 32'd0);
      @(negedge clk);
    end
    imem_ack = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("t3_next_addr", imem_addr, 32'h14);
    check("t3_count", fetch_count, 32'd5);

    // Grant withheld 3 cycles, then ack 4 cycles after grant
    for (int i = 0; i < 3; i++) begin
      check("t5_req_hold", 32'(imem_req), 32'd1);
      check("t5_addr_hold", imem_addr, 32'h14);
      @(negedge clk);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_no_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    check("t5_no_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0513;
    @(negedge clk);
    imem_ack = 1'b0;
    check("t5_valid", 32'(instr_valid), 32'd1);
    check("t5_instr", instr, 32'h00A0_0513);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("t5_next_addr", imem_addr, 32'h18);
    check("t5_count", fetch_count, 32'd6);

    // Reset during WAIT; stale ack after reset must be dropped
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("t6_in_wait", 32'(imem_req), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_req_in_rst", 32'(imem_req), 32'd0);
    check("t6_pc", pc, 32'd0);
    check("t6_count", fetch_count, 32'd0);
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    check("t6_ack_dropped", 32'(instr_valid), 32'd0);
    check("t6_instr", instr, 32'h0000_0013);
    check("t6_addr", imem_addr, 32'd0);
    check("t6_req", 32'(imem_req), 32'd1);

    // Branch redirect from pc 8 to a misaligned target
    do_fetch(32'h0, 32'h0000_0093, 1'b0, 32'd0);
    do_fetch(32'h4, 32'h0000_0113, 1'b0, 32'd0);
    check("t4_count_before", fetch_count, 32'd2);
    do_fetch(32'h8, 32'h0000_0063, 1'b1, 32'h43);
    check("t4_target", imem_addr, 32'h40);
    check("t4_count", fetch_count, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
